// File: rtl/tdp_ram_clr.sv
// True-dual-port single-clock sample RAM. It adds per-port read-valid strobes, a selectable
// read-during-write mode, an optional output register and a clear sweep that zeroes the array.
module tdp_ram_clr #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDR_WIDTH    = 10,
    parameter int SIZE          = 1024,
    parameter int RDW_MODE      = 0,
    parameter int OUT_REG       = 0,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    output logic                  busy,
    input  logic                  en_a,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] data_a,
    output logic [DATA_WIDTH-1:0] q_a,
    output logic                  valid_a,
    input  logic                  en_b,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] data_b,
    output logic [DATA_WIDTH-1:0] q_b,
    output logic                  valid_b,
    output logic                  collision
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SIZE - 1);
    localparam logic [ADDR_WIDTH:0]   SIZE_EXT  = (ADDR_WIDTH + 1)'(SIZE);

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   ptr;
    logic [DATA_WIDTH-1:0]   ram [0:SIZE-1];

    logic                    acc_a, acc_b, wr_a, wr_b, in_a, in_b, coll;
    logic [DATA_WIDTH-1:0]   rd_a, rd_b;

    logic [DATA_WIDTH-1:0]   q_a_p1, q_b_p1;
    logic                    vld_a_p1, vld_b_p1, coll_p1;

    assign busy  = (state == CLEAR);
    assign acc_a = en_a && !busy;
    assign acc_b = en_b && !busy;
    assign wr_a  = acc_a && we_a;
    assign wr_b  = acc_b && we_b;
    assign in_a  = ({1'b0, addr_a} < SIZE_EXT);
    assign in_b  = ({1'b0, addr_b} < SIZE_EXT);
    assign coll  = wr_a && wr_b && (addr_a == addr_b);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (clear) state_next = CLEAR;
            CLEAR:   if (ptr == LAST_ADDR) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= (INIT_ON_RESET != 0) ? CLEAR : IDLE;
            ptr   <= '0;
        end else begin
            state <= state_next;
            if (state == CLEAR && ptr != LAST_ADDR)
                ptr <= ptr + 1'b1;
            else
                ptr <= '0;
        end
    end

    // Port B's write-first return shows what actually got stored, which is A's data on a collision.
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        if (in_a)
            rd_a = (we_a && RDW_MODE == 0) ? data_a : ram[addr_a];
        if (in_b)
            rd_b = (we_b && RDW_MODE == 0) ? (coll ? data_a : data_b) : ram[addr_b];
    end

    // The sweep borrows port A's write path; B's write loses any same-address collision.
    always_ff @(posedge clk) begin
        if (busy) begin
            ram[ptr] <= '0;
        end else begin
            if (wr_a && in_a)
                ram[addr_a] <= data_a;
            if (wr_b && in_b && !coll)
                ram[addr_b] <= data_b;
        end
    end

    // Stage p1: read data and strobes, one cycle after the access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_a_p1   <= '0;
            q_b_p1   <= '0;
            vld_a_p1 <= 1'b0;
            vld_b_p1 <= 1'b0;
            coll_p1  <= 1'b0;
        end else begin
            vld_a_p1 <= acc_a;
            vld_b_p1 <= acc_b;
            coll_p1  <= coll;
            if (acc_a) q_a_p1 <= rd_a;
            if (acc_b) q_b_p1 <= rd_b;
        end
    end

    assign collision = coll_p1;

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] q_a_p2, q_b_p2;
            logic                  vld_a_p2, vld_b_p2;

            // Stage p2: optional output register
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_a_p2   <= '0;
                    q_b_p2   <= '0;
                    vld_a_p2 <= 1'b0;
                    vld_b_p2 <= 1'b0;
                end else begin
                    vld_a_p2 <= vld_a_p1;
                    vld_b_p2 <= vld_b_p1;
                    if (vld_a_p1) q_a_p2 <= q_a_p1;
                    if (vld_b_p1) q_b_p2 <= q_b_p1;
                end
            end

            assign q_a     = q_a_p2;
            assign q_b     = q_b_p2;
            assign valid_a = vld_a_p2;
            assign valid_b = vld_b_p2;
        end else begin : g_no_out_reg
            assign q_a     = q_a_p1;
            assign q_b     = q_b_p1;
            assign valid_a = vld_a_p1;
            assign valid_b = vld_b_p1;
        end
    endgenerate

endmodule
